// File: rtl/pll_mgr_pkg.sv
// Shared definitions for the PLL lock manager: FSM state encoding and counter sizing.
package pll_mgr_pkg;

    typedef logic [2:0] pll_state_t;

    localparam pll_state_t PLL_RST   = 3'd0;
    localparam pll_state_t WAIT_LOCK = 3'd1;
    localparam pll_state_t STABLE    = 3'd2;
    localparam pll_state_t RUN       = 3'd3;
    localparam pll_state_t FAULT     = 3'd4;

    // Counter width for a counter that must reach the given limit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return 32'($clog2(limit) + 1);
    endfunction

endpackage

// File: rtl/pll_ce_accum.sv
// One fractional clock-enable channel: phase accumulator with registered carry strobe.
module pll_ce_accum #(
    parameter int unsigned ACC_W = 16
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             en,
    input  logic [ACC_W-1:0] inc,
    output logic             ce
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, inc};

    // Accumulator and strobe are held at zero whenever the channel is not running.
    always_ff @(posedge clkin) begin
        if (reset || !en) begin
            acc <= '0;
            ce  <= 1'b0;
        end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= sum[ACC_W];
        end
    end

endmodule

// File: rtl/pll_lock_manager.sv
// PLL supervisor: drives PLL reset, qualifies lock, sequences system reset and clock enables.
module pll_lock_manager
    import pll_mgr_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 7,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned ACC_W         = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic                    pll_lock,
    input  logic [NUM_CH*ACC_W-1:0] ch_inc,
    output logic                    pll_reset,
    output logic                    rst_out,
    output logic                    locked,
    output logic [NUM_CH-1:0]       ce,
    output logic [CNT_W-1:0]        relock_cnt,
    output logic                    timeout_err
);

    localparam int unsigned RST_W = cnt_width(RST_CYCLES);
    localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT);
    localparam int unsigned STB_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned RTY_W = cnt_width(MAX_RETRY);

    pll_state_t              state, state_next;
    logic [1:0]              lock_sync;
    logic                    lock_s;
    logic [RST_W-1:0]        rst_cnt, rst_cnt_next;
    logic [TMO_W-1:0]        timer, timer_next;
    logic [STB_W-1:0]        stable_cnt, stable_cnt_next;
    logic [RTY_W-1:0]        retry_cnt, retry_cnt_next;
    logic                    latch_inc;
    logic                    relock_evt;
    logic                    acc_en;
    logic [NUM_CH*ACC_W-1:0] inc_q;

    assign lock_s = lock_sync[1];

    // Next-state and counter logic.
    always_comb begin
        state_next      = state;
        rst_cnt_next    = rst_cnt;
        timer_next      = timer;
        stable_cnt_next = stable_cnt;
        retry_cnt_next  = retry_cnt;
        latch_inc       = 1'b0;
        relock_evt      = 1'b0;
        case (state)
            PLL_RST: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else begin
                    rst_cnt_next = rst_cnt + RST_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock takes precedence over a timeout expiring in the same cycle.
                if (lock_s) begin
                    state_next      = STABLE;
                    stable_cnt_next = '0;
                end else if (timer == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    retry_cnt_next = retry_cnt + RTY_W'(1);
                    rst_cnt_next   = '0;
                    state_next     = (retry_cnt == RTY_W'(MAX_RETRY - 1)) ? FAULT : PLL_RST;
                end else begin
                    timer_next = timer + TMO_W'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (stable_cnt == STB_W'(STABLE_CYCLES - 1)) begin
                    state_next     = RUN;
                    latch_inc      = 1'b1;
                    retry_cnt_next = '0;
                end else begin
                    stable_cnt_next = stable_cnt + STB_W'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next   = PLL_RST;
                    rst_cnt_next = '0;
                    relock_evt   = 1'b1;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next   = PLL_RST;
                rst_cnt_next = '0;
            end
        endcase
    end

    // Accumulators only advance while staying in RUN, so ce drops with rst_out on lock loss.
    assign acc_en = (state == RUN) && (state_next == RUN);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= PLL_RST;
            lock_sync   <= 2'b00;
            rst_cnt     <= '0;
            timer       <= '0;
            stable_cnt  <= '0;
            retry_cnt   <= '0;
            inc_q       <= '0;
            relock_cnt  <= '0;
            pll_reset   <= 1'b1;
            rst_out     <= 1'b1;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            lock_sync   <= {lock_sync[0], pll_lock};
            rst_cnt     <= rst_cnt_next;
            timer       <= timer_next;
            stable_cnt  <= stable_cnt_next;
            retry_cnt   <= retry_cnt_next;
            if (latch_inc) begin
                inc_q <= ch_inc;
            end
            if (relock_evt && (relock_cnt != '1)) begin
                relock_cnt <= relock_cnt + CNT_W'(1);
            end
            pll_reset   <= (state_next == PLL_RST) || (state_next == FAULT);
            rst_out     <= (state_next != RUN);
            locked      <= (state_next == RUN);
            timeout_err <= (state_next == FAULT);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pll_ce_accum #(
            .ACC_W (ACC_W)
        ) u_accum (
            .clkin (clkin),
            .reset (reset),
            .en    (acc_en),
            .inc   (inc_q[i*ACC_W +: ACC_W]),
            .ce    (ce[i])
        );
    end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Directed self-checking bench for pll_lock_manager with small parameters.
module tb_pll_lock_manager;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned ACC_W  = 8;
    localparam int unsigned CNT_W  = 8;
    localparam logic [NUM_CH*ACC_W-1:0] INC_DEFAULT = 32'hFF00_4080;

    logic                    clkin = 1'b0;
    logic                    reset;
    logic                    pll_lock;
    logic [NUM_CH*ACC_W-1:0] ch_inc;
    logic                    pll_reset;
    logic                    rst_out;
    logic                    locked;
    logic [NUM_CH-1:0]       ce;
    logic [CNT_W-1:0]        relock_cnt;
    logic                    timeout_err;

    int checks = 0;
    int fails  = 0;

    always #5 clkin = ~clkin;

    pll_lock_manager #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (3),
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .CNT_W         (CNT_W)
    ) dut (
        .clkin       (clkin),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .ch_inc      (ch_inc),
        .pll_reset   (pll_reset),
        .rst_out     (rst_out),
        .locked      (locked),
        .ce          (ce),
        .relock_cnt  (relock_cnt),
        .timeout_err (timeout_err)
    );

    // Number of consecutive high pll_reset samples starting at the current one.
    task automatic measure_high(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (pll_reset !== 1'b1) break;
            n++;
            @(negedge clkin);
        end
    endtask

    // Number of negedges until locked is seen high (100 means never).
    task automatic cycles_to_locked(output int k);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clkin);
            k++;
            if (locked === 1'b1) break;
        end
    endtask

    task automatic start_reset(input logic lock_level);
        @(negedge clkin);
        reset    = 1'b1;
        pll_lock = lock_level;
        repeat (2) @(negedge clkin);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        @(negedge clkin);
        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (2) @(negedge clkin);
        checks++;
        if (pll_reset !== 1'b1 || rst_out !== 1'b1 || locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: pll_reset=%b rst_out=%b locked=%b, required 1 1 0", pll_reset, rst_out, locked);
        end
        checks++;
        if (ce !== 4'b0000 || relock_cnt !== 8'd0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_stat: ce=%b relock_cnt=%0d timeout_err=%b, required 0 0 0", ce, relock_cnt, timeout_err);
        end
        reset = 1'b0;
        measure_high(n);
        checks++;
        if (n !== 4) begin
            fails++;
            $display("FAIL reset_pulse: pll_reset high %0d cycles, required 4", n);
        end
    endtask

    task automatic test_bringup();
        int k;
        repeat (3) @(negedge clkin);
        pll_lock = 1'b1;
        cycles_to_locked(k);
        checks++;
        if (k !== 11) begin
            fails++;
            $display("FAIL bringup_latency: locked after %0d cycles, required 11", k);
        end
        checks++;
        if (rst_out !== 1'b0 || pll_reset !== 1'b0 || relock_cnt !== 8'd0) begin
            fails++;
            $display("FAIL bringup_state: rst_out=%b pll_reset=%b relock_cnt=%0d, required 0 0 0", rst_out, pll_reset, relock_cnt);
        end
    endtask

    task automatic test_glitch();
        int n;
        int k;
        start_reset(1'b0);
        measure_high(n);
        pll_lock = 1'b1;
        repeat (6) @(negedge clkin);
        pll_lock = 1'b0;
        @(negedge clkin);
        pll_lock = 1'b1;
        checks++;
        if (locked !== 1'b0 || rst_out !== 1'b1) begin
            fails++;
            $display("FAIL glitch_pre: locked=%b rst_out=%b, required 0 1", locked, rst_out);
        end
        cycles_to_locked(k);
        checks++;
        if (k !== 11) begin
            fails++;
            $display("FAIL glitch_restart: locked after %0d cycles, required 11", k);
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL glitch_fault: timeout_err=%b, required 0", timeout_err);
        end
    endtask

    task automatic test_loss_of_lock();
        int  k;
        int  n;
        int  exp_cnt;
        bit  seen;
        pll_lock = 1'b0;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clkin);
            k++;
            if (rst_out === 1'b1) break;
        end
        checks++;
        if (k !== 3) begin
            fails++;
            $display("FAIL loss_latency: rst_out rose after %0d cycles, required 3", k);
        end
        checks++;
        if (ce !== 4'b0000 || locked !== 1'b0 || relock_cnt !== 8'd1) begin
            fails++;
            $display("FAIL loss_state: ce=%b locked=%b relock_cnt=%0d, required 0 0 1", ce, locked, relock_cnt);
        end
        measure_high(n);
        checks++;
        if (n !== 4) begin
            fails++;
            $display("FAIL loss_pulse: pll_reset high %0d cycles, required 4", n);
        end
        pll_lock = 1'b1;
        cycles_to_locked(k);
        checks++;
        if (k !== 11) begin
            fails++;
            $display("FAIL loss_relock: locked after %0d cycles, required 11", k);
        end
        for (int it = 2; it <= 300; it++) begin
            exp_cnt  = (it > 255) ? 255 : it;
            pll_lock = 1'b0;
            seen     = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clkin);
                if (rst_out === 1'b1) begin
                    seen = 1'b1;
                    break;
                end
            end
            pll_lock = 1'b1;
            cycles_to_locked(k);
            checks++;
            if (!seen || k >= 100 || relock_cnt !== CNT_W'(exp_cnt)) begin
                fails++;
                $display("FAIL relock_iter: iter %0d rst_seen=%b lock_cycles=%0d relock_cnt=%0d, required 1 <100 %0d",
                         it, seen, k, relock_cnt, exp_cnt);
            end
        end
        checks++;
        if (relock_cnt !== 8'd255) begin
            fails++;
            $display("FAIL relock_sat: relock_cnt=%0d, required 255", relock_cnt);
        end
    endtask

    task automatic test_strobe();
        int k;
        int lost;
        int cnt [NUM_CH];
        int exp_ce [NUM_CH] = '{128, 64, 0, 255};
        start_reset(1'b0);
        pll_lock = 1'b1;
        cycles_to_locked(k);
        checks++;
        if (k !== 13) begin
            fails++;
            $display("FAIL strobe_lock: locked after %0d cycles, required 13", k);
        end
        checks++;
        if (ce !== 4'b0000) begin
            fails++;
            $display("FAIL strobe_entry: ce=%b, required 0000", ce);
        end
        lost = 0;
        for (int j = 0; j < NUM_CH; j++) cnt[j] = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 100) ch_inc = 32'h0101_0101;
            @(negedge clkin);
            if (locked !== 1'b1) lost++;
            for (int j = 0; j < NUM_CH; j++) cnt[j] += (ce[j] === 1'b1) ? 1 : 0;
        end
        ch_inc = INC_DEFAULT;
        checks++;
        if (lost !== 0) begin
            fails++;
            $display("FAIL strobe_run: locked low for %0d cycles, required 0", lost);
        end
        for (int j = 0; j < NUM_CH; j++) begin
            checks++;
            if (cnt[j] !== exp_ce[j]) begin
                fails++;
                $display("FAIL strobe_ch%0d: %0d strobes, required %0d", j, cnt[j], exp_ce[j]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int k;
        @(negedge clkin);
        reset = 1'b1;
        @(negedge clkin);
        checks++;
        if (pll_reset !== 1'b1 || rst_out !== 1'b1 || locked !== 1'b0 ||
            ce !== 4'b0000 || relock_cnt !== 8'd0 || timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL midrun_reset: pll_reset=%b rst_out=%b locked=%b ce=%b relock_cnt=%0d timeout_err=%b, required 1 1 0 0000 0 0",
                     pll_reset, rst_out, locked, ce, relock_cnt, timeout_err);
        end
        reset = 1'b0;
        measure_high(n);
        checks++;
        if (n !== 4) begin
            fails++;
            $display("FAIL midrun_pulse: pll_reset high %0d cycles, required 4", n);
        end
        cycles_to_locked(k);
        checks++;
        if (k !== 9) begin
            fails++;
            $display("FAIL midrun_relock: locked after %0d cycles, required 9", k);
        end
    endtask

    task automatic test_timeout();
        int n;
        int m;
        int drops;
        start_reset(1'b0);
        for (int p = 0; p < 3; p++) begin
            measure_high(n);
            checks++;
            if (n !== 4) begin
                fails++;
                $display("FAIL timeout_pulse%0d: pll_reset high %0d cycles, required 4", p, n);
            end
            m = 0;
            for (int i = 0; i < 100; i++) begin
                if (pll_reset !== 1'b0) break;
                m++;
                @(negedge clkin);
            end
            checks++;
            if (m !== 32) begin
                fails++;
                $display("FAIL timeout_gap%0d: pll_reset low %0d cycles, required 32", p, m);
            end
            checks++;
            if (timeout_err !== (p == 2)) begin
                fails++;
                $display("FAIL timeout_flag%0d: timeout_err=%b, required %0d", p, timeout_err, (p == 2));
            end
        end
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkin);
            if (pll_reset !== 1'b1 || timeout_err !== 1'b1 || rst_out !== 1'b1 || locked !== 1'b0) drops++;
        end
        checks++;
        if (drops !== 0) begin
            fails++;
            $display("FAIL fault_hold: fault outputs wrong in %0d cycles, required 0", drops);
        end
        reset = 1'b1;
        @(negedge clkin);
        reset = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || pll_reset !== 1'b1) begin
            fails++;
            $display("FAIL fault_clear: timeout_err=%b pll_reset=%b, required 0 1", timeout_err, pll_reset);
        end
    endtask

    initial begin
        reset    = 1'b1;
        pll_lock = 1'b0;
        ch_inc   = INC_DEFAULT;
        test_reset();
        test_bringup();
        test_glitch();
        test_loss_of_lock();
        test_strobe();
        test_reset_mid_run();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
